// File: rtl/data_mem_responder.sv
// Single-port doubleword data memory answering one load/store at a time; DMEM_MISALIGN_TRAP_EN turns misalignment into an error.
// Latency: rsp_valid rises LATENCY+1 cycles after the accept edge; memory update and load sample happen on the edge entering RESP.
// Backpressure: the response is held until rsp_ready; req_ready is low from accept until the response is consumed.
module data_mem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_write;
    logic [63:0] l_addr;
    logic [63:0] l_wdata;
    logic [1:0]  l_size;
    logic        l_unsigned;
    logic [63:0] mem [DEPTH];

    logic          a_write;
    logic [63:0]   a_addr;
    logic [63:0]   a_wdata;
    logic [1:0]    a_size;
    logic          a_unsigned;
    logic          accept;
    logic          go_resp;
    logic [2:0]    align_mask;
    logic [63:0]   size_mask;
    logic [63:0]   lane_mask;
    logic [63:0]   eff_addr;
    logic [2:0]    lane;
    logic [AW-1:0] idx;
    logic          oor;
    logic          err;
    logic [63:0]   old_dw;
    logic [63:0]   new_dw;
    logic [63:0]   shifted;
    logic [63:0]   ld_data;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic          misalign;
`endif

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    // With LATENCY == 0 the access completes on the accept edge itself, so it must use the live request.
    assign go_resp   = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'(LATENCY - 1)));

    always_comb begin
        if (state == IDLE) begin
            a_write    = req_write;
            a_addr     = req_addr;
            a_wdata    = req_wdata;
            a_size     = req_size;
            a_unsigned = req_unsigned;
        end else begin
            a_write    = l_write;
            a_addr     = l_addr;
            a_wdata    = l_wdata;
            a_size     = l_size;
            a_unsigned = l_unsigned;
        end

        case (a_size)
            2'd0:    begin align_mask = 3'b000; size_mask = 64'h0000_0000_0000_00ff; end
            2'd1:    begin align_mask = 3'b001; size_mask = 64'h0000_0000_0000_ffff; end
            2'd2:    begin align_mask = 3'b011; size_mask = 64'h0000_0000_ffff_ffff; end
            default: begin align_mask = 3'b111; size_mask = 64'hffff_ffff_ffff_ffff; end
        endcase

        oor = |a_addr[63:3+AW];
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = |(a_addr[2:0] & align_mask);
        eff_addr = a_addr;
        err      = oor || misalign;
`else
        eff_addr = {a_addr[63:3], a_addr[2:0] & ~align_mask};
        err      = oor;
`endif

        lane      = eff_addr[2:0];
        idx       = eff_addr[3+AW-1:3];
        old_dw    = mem[idx];
        lane_mask = size_mask << {lane, 3'b000};
        new_dw    = (old_dw & ~lane_mask) | ((a_wdata << {lane, 3'b000}) & lane_mask);
        shifted   = old_dw >> {lane, 3'b000};

        case (a_size)
            2'd0:    ld_data = a_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1:    ld_data = a_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    ld_data = a_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_write    <= req_write;
                        l_addr     <= req_addr;
                        l_wdata    <= req_wdata;
                        l_size     <= req_size;
                        l_unsigned <= req_unsigned;
                        cnt        <= 4'd0;
                        if (LATENCY == 0) state <= RESP;
                        else              state <= WAIT;
                    end
                end
                WAIT: begin
                    if (go_resp) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (go_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (a_write || err) ? 64'd0 : ld_data;
            end
        end
    end

    // Contents survive reset; a commit coinciding with reset low is dropped.
    always_ff @(posedge clk) begin
        if (reset && go_resp && a_write && !err) begin
            mem[idx] <= new_dw;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array reference memory.
module tb_data_mem_responder;
    localparam int DEPTH   = 32;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mref [DEPTH*8];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain byte memory, size in bytes, alignment rules applied arithmetically.
    task automatic ref_access(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                              input logic [1:0] sz, input bit uns,
                              output logic [63:0] er, output bit ee);
        int n;
        logic [63:0] a;
        logic [63:0] v;
        n  = 1 << sz;
        a  = addr;
        v  = 64'd0;
        er = 64'd0;
        ee = (addr >= 64'(DEPTH * 8));
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((addr % 64'(n)) != 0) ee = 1'b1;
`else
        a = addr - (addr % 64'(n));
`endif
        if (ee) return;
        if (wr) begin
            for (int i = 0; i < n; i++) mref[int'(a) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = mref[int'(a) + i];
            if (!uns && n < 8 && v[8*n-1]) begin
                for (int j = 8 * n; j < 64; j++) v[j] = 1'b1;
            end
            er = v;
        end
    endtask

    task automatic scramble_req();
        req_write    = 1'($urandom);
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
    endtask

    task automatic txn(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [1:0] sz, input bit uns, input int hold);
        logic [63:0] er;
        bit ee;
        int cyc;
        ref_access(wr, addr, wd, sz, uns, er, ee);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        req_size = sz; req_unsigned = uns;
        cyc = 0;
        while (!req_ready && cyc < 40) begin @(posedge clk); #1; cyc++; end
        if (!req_ready) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble_req();
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check_eq("rsp_latency", 64'(cyc), 64'(LATENCY + 1));
        check_eq("rsp_err", 64'(rsp_err), 64'(ee));
        check_eq("rsp_rdata", rsp_rdata, er);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom);
            scramble_req();
            @(posedge clk); #1;
            check_eq("hold_valid", 64'(rsp_valid), 64'd1);
            check_eq("hold_rdata", rsp_rdata, er);
            check_eq("hold_err", 64'(rsp_err), 64'(ee));
            check_eq("hold_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("rsp_drop", 64'(rsp_valid), 64'd0);
        check_eq("ready_back", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_req_ready", 64'(req_ready), 64'd1);
        check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("reset_rsp_rdata", rsp_rdata, 64'd0);
        check_eq("reset_rsp_err", 64'(rsp_err), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 64'(i * 8), {$urandom, $urandom}, 2'd3, 1'b0, 0);

        txn(1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, 0);
        txn(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0);

        txn(1'b1, 64'h13, 64'hF0, 2'd0, 1'b0, 0);
        txn(1'b0, 64'h13, 64'd0, 2'd0, 1'b0, 0);
        txn(1'b0, 64'h13, 64'd0, 2'd0, 1'b1, 0);
        txn(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0);

        txn(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 5);

        txn(1'b0, 64'h100, 64'd0, 2'd3, 1'b0, 0);
        txn(1'b1, 64'h100, 64'hDEADBEEFCAFEF00D, 2'd3, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) txn(1'b0, 64'(i * 8), 64'd0, 2'd3, 1'b0, 0);

        txn(1'b1, 64'h11, 64'h0000ABCD, 2'd1, 1'b0, 0);
        txn(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0);

        // Store to 0x08 dropped by reset while waiting; model is left untouched.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h08;
        req_wdata = 64'h0123456789ABCDEF; req_size = 2'd3; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_eq("rst_wait_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_wait_rsp_valid", 64'(rsp_valid), 64'd0);
        txn(1'b0, 64'h08, 64'd0, 2'd3, 1'b0, 0);

        repeat (150) begin
            a = 64'($urandom_range(0, DEPTH * 8 - 1));
            if ($urandom_range(0, 9) == 0) a = a | (64'd1 << $urandom_range(8, 63));
            txn(1'($urandom), a, {$urandom, $urandom}, 2'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of 64-bit doublewords stored; power of 2, 2..1024.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles inserted before each response; range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_wdata  input  64  store data, right-justified.
REQ-010 SHALL have port req_size  input  2  access size (funct3[1:0]): 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 SHALL have port req_unsigned  input  1  funct3[2]: zero-extend load data.
REQ-012 SHALL have port rsp_valid  output  1  response held on rsp_rdata/rsp_err.
REQ-013 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-014 SHALL have port rsp_rdata  output  64  load result; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  access faulted; no state changed.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = (state == IDLE).
REQ-017 SHALL accept a request on an edge where req_valid && req_ready, latching write, addr, wdata, size and unsigned.
REQ-018 SHALL go from IDLE to WAIT on accept when LATENCY > 0, else directly to RESP; WAIT SHALL count LATENCY cycles, then go to RESP.
REQ-019 SHALL first assert rsp_valid exactly LATENCY+1 cycles after the accept edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready is high; on that edge SHALL go to IDLE and clear rsp_valid. req_ready is high the following cycle, giving at most one request per LATENCY+2 cycles.
REQ-021 SHALL ignore request inputs while not in IDLE.
REQ-022 SHALL store little-endian: doubleword index addr[3+log2(DEPTH)-1:3], byte lane addr[2:0].
REQ-023 SHALL commit a store on the edge entering RESP, updating only the 1/2/4/8 addressed byte lanes from the low bytes of req_wdata.
REQ-024 SHALL sample load data on the edge entering RESP, extract the addressed lanes and sign-extend (or zero-extend if req_unsigned) to 64 bits; a double ignores req_unsigned.
REQ-025 SHALL flag rsp_err = 1 when any of addr[63:3+log2(DEPTH)] is nonzero (out of range); the store is then suppressed and rsp_rdata = 0.
REQ-026 SHALL return rsp_rdata = 0 for stores.
REQ-027 SHALL give a load of an address stored by the previous transaction the new data.

Reset
REQ-028 SHALL, on any edge with reset low: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
REQ-029 SHALL drop an in-flight transaction on reset; a store not yet committed SHALL NOT be written.
REQ-030 SHALL NOT reset memory contents.

Configuration
REQ-031 SHALL, with DMEM_MISALIGN_TRAP_EN defined, treat an access whose addr is not size-aligned as an error: rsp_err = 1, rsp_rdata = 0, no store.
REQ-032 SHALL, without DMEM_MISALIGN_TRAP_EN, clear the low log2(bytes) addr bits before the access (force alignment); misalignment SHALL NOT raise rsp_err.

Verification
REQ-033 SHALL cover this scenario: LATENCY = 2; store double 0x1122334455667788 at 0x10 -> rsp_valid on cycle 3 after accept, rsp_err = 0; a load double at 0x10 returns 0x1122334455667788.
REQ-034 SHALL cover this scenario: store byte 0xF0 at 0x13, then signed load byte at 0x13 -> 0xFFFFFFFFFFFFFFF0; unsigned load -> 0x00000000000000F0; the other lanes of doubleword 2 are unchanged.
REQ-035 SHALL cover this scenario: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready = 0, and a req_valid pulse is ignored.
REQ-036 SHALL cover this scenario: DEPTH = 32, load at 0x100 -> rsp_err = 1, rsp_rdata = 0; store at 0x100 leaves all memory unchanged.
REQ-037 SHALL cover this scenario: half access at 0x11 -> with DMEM_MISALIGN_TRAP_EN, rsp_err = 1; without it, the access is performed at 0x10.
REQ-038 SHALL cover this scenario: reset low during WAIT of a store to 0x08 -> next cycle req_ready = 1, rsp_valid = 0; a load at 0x08 returns the old value.
